// File: rtl/spiflash_responder.sv
// Word-read port onto a SPI flash (READ 0x03, mode 0); reads complete at T0+1+128*HALF_PERIOD, writes are acked at T0+1.
// Define SPIFLASH_SEQ_EN to keep the flash selected after a read so the next sequential word streams without a new command.
module spiflash_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0010_0000,
    parameter logic [31:0] WINDOW_BYTES = 32'h0010_0000,
    parameter int          HALF_PERIOD  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    output logic        sel,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        flash_csn,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        busy
);
    localparam int CW = $clog2(2 * HALF_PERIOD) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * HALF_PERIOD - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACK  = 3'd1;
    localparam logic [2:0] S_CMD  = 3'd2;
    localparam logic [2:0] S_ADDR = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_GAP  = 3'd6;
`ifdef SPIFLASH_SEQ_EN
    localparam logic [2:0] S_HOLD = 3'd7;
`endif

    logic [2:0]    state;
    logic [CW-1:0] tick;
    logic [5:0]    bit_cnt;
    logic [31:0]   tx_sr;
    logic [31:0]   rx_sr;
    logic          hit;
    logic          is_read;
    logic          half_done;
    logic [31:0]   rx_next;
    logic [31:0]   rx_word;
    logic [31:0]   start_word;

    // Offset compare handles the window end without needing a 33-bit sum.
    assign hit        = (mem_addr - BASE_ADDR) < WINDOW_BYTES;
    assign sel        = mem_valid && hit;
    assign busy       = (state != S_IDLE);
    assign is_read    = (mem_wstrb == 4'b0000);
    assign half_done  = (tick == HALF_LAST);
    assign rx_next    = {rx_sr[30:0], flash_miso};
    assign rx_word    = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
    assign start_word = {8'h03, mem_addr[23:2], 2'b00};
    // Command+address shift out of the top bit; zero fill makes MOSI 0 throughout DATA.
    assign flash_mosi = tx_sr[31];

`ifdef SPIFLASH_SEQ_EN
    logic [21:0] last_word;
    logic        seq_hit;
    assign seq_hit = is_read && (mem_addr[23:2] == 22'(last_word + 22'd1));
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            flash_csn <= 1'b1;
            flash_clk <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
`ifdef SPIFLASH_SEQ_EN
            last_word <= '0;
`endif
        end else begin
            mem_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel) begin
                        tick <= '0;
                        if (is_read) begin
                            state     <= S_CMD;
                            tx_sr     <= start_word;
                            bit_cnt   <= '0;
                            flash_csn <= 1'b0;
`ifdef SPIFLASH_SEQ_EN
                            last_word <= mem_addr[23:2];
`endif
                        end else begin
                            state     <= S_ACK;
                            mem_ready <= 1'b1;
                        end
                    end
                end
                S_ACK: state <= S_IDLE;
                S_CMD, S_ADDR, S_DATA: begin
                    if (!half_done) begin
                        tick <= tick + CW'(1);
                    end else begin
                        tick      <= '0;
                        flash_clk <= ~flash_clk;
                        // End of the SCK-high phase: sample MISO and advance one bit.
                        if (flash_clk) begin
                            rx_sr   <= rx_next;
                            tx_sr   <= {tx_sr[30:0], 1'b0};
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd7) begin
                                state <= S_ADDR;
                            end else if (bit_cnt == 6'd31) begin
                                state <= S_DATA;
                            end else if (bit_cnt == 6'd63) begin
                                state <= S_DONE;
                                if (mem_valid) begin
                                    mem_ready <= 1'b1;
                                    mem_rdata <= rx_word;
                                end
`ifndef SPIFLASH_SEQ_EN
                                flash_csn <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef SPIFLASH_SEQ_EN
                S_DONE: state <= S_HOLD;
                S_HOLD: begin
                    if (sel) begin
                        tick <= '0;
                        if (seq_hit) begin
                            state     <= S_DATA;
                            bit_cnt   <= 6'd32;
                            last_word <= mem_addr[23:2];
                        end else begin
                            state     <= S_GAP;
                            flash_csn <= 1'b1;
                        end
                    end
                end
`else
                S_DONE: state <= S_GAP;
`endif
                S_GAP: begin
                    if (tick == GAP_LAST) begin
                        state <= S_IDLE;
                        tick  <= '0;
                    end else begin
                        tick <= tick + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spiflash_responder.sv
// Directed bench for spiflash_responder with a behavioural SPI flash (byte content from fbyte()).
module tb_spiflash_responder;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        sel;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        flash_csn;
    logic        flash_clk;
    logic        flash_mosi;
    logic        flash_miso = 1'b0;
    logic        busy;

    spiflash_responder dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .sel        (sel),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .flash_csn  (flash_csn),
        .flash_clk  (flash_clk),
        .flash_mosi (flash_mosi),
        .flash_miso (flash_miso),
        .busy       (busy)
    );

    always #5 clk = ~clk;

`ifdef SPIFLASH_SEQ_EN
    localparam int SEQ_LAT   = 129;
    localparam int WR_LAT    = 6;
    localparam int GAP_BUSY  = 20;
`else
    localparam int SEQ_LAT   = 257;
    localparam int WR_LAT    = 1;
    localparam int GAP_BUSY  = 4;
`endif

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        fbyte = 8'(({4'd0, a[3:0]} + 8'd1) * 8'h11) ^ a[11:4];
    endfunction

    // Flash model: header capture on SCK rise, data driven on SCK fall.
    int          nbits = 0;
    int          n_fall = 0;
    int          n_rise = 0;
    int          nhdr = 0;
    int          sck_err = 0;
    int          hi_run = 0;
    int          last_gap = 0;
    logic [31:0] fsh = '0;
    logic [7:0]  cap_cmd = '0;
    logic [23:0] cap_addr = '0;

    always @(posedge flash_clk or negedge flash_csn) begin
        if (flash_clk === 1'b1) begin
            if (flash_csn !== 1'b0) begin
                sck_err++;
            end else begin
                fsh = {fsh[30:0], flash_mosi};
                nbits++;
                if (nbits == 32) begin
                    cap_cmd  = fsh[31:24];
                    cap_addr = fsh[23:0];
                    nhdr++;
                end
            end
        end else begin
            nbits = 0;
            n_fall++;
        end
    end

    always @(negedge flash_clk) begin
        if (flash_csn === 1'b0 && nbits >= 32) begin
            automatic int d = nbits - 32;
            automatic logic [7:0] b = fbyte(cap_addr + 24'(d / 8));
            flash_miso = b[7 - (d % 8)];
        end
    end

    always @(posedge flash_csn) n_rise++;

    always @(negedge clk) begin
        if (flash_csn === 1'b1) begin
            hi_run++;
        end else if (flash_csn === 1'b0) begin
            if (hi_run > 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    int          op_lat;
    logic [31:0] op_data;
    logic        op_sel;
    logic        op_csn1;
    logic        op_rdy_after;

    // Issue one request; op_lat is the cycle offset from T0 of mem_ready, -1 if none within bound.
    task automatic run_op(input logic [31:0] addr, input logic [3:0] wstrb, input int bound);
        @(posedge clk);
        #1;
        mem_addr  = addr;
        mem_wstrb = wstrb;
        mem_valid = 1'b1;
        #1 op_sel = sel;
        op_lat       = -1;
        op_csn1      = 1'b1;
        op_rdy_after = 1'b0;
        op_data      = '0;
        for (int c = 1; c <= bound; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) op_csn1 = flash_csn;
            if (mem_ready) begin
                op_lat  = c;
                op_data = mem_rdata;
                break;
            end
        end
        if (op_lat > 0) begin
            @(posedge clk);
            #1 op_rdy_after = mem_ready;
        end
        mem_valid = 1'b0;
        mem_wstrb = '0;
    endtask

    task automatic do_reset();
        mem_valid = 1'b0;
        mem_wstrb = '0;
        resetn    = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic        hit;
        int          lat;
        logic [31:0] data;
        logic [23:0] faddr;
    } vec_t;

    vec_t vt[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, h0, r0, bc;
        logic rdy_seen;

        vt[0] = '{32'h0010_0000, 4'h0, 1'b1, 257, 32'h4433_2211, 24'h10_0000};
        vt[1] = '{32'h0010_0006, 4'h0, 1'b1, 257, 32'h8877_6655, 24'h10_0004};
        vt[2] = '{32'h0010_0103, 4'h0, 1'b1, 257, 32'h5423_3201, 24'h10_0100};
        vt[3] = '{32'h001F_FFFC, 4'h0, 1'b1, 257, 32'hEF00_1122, 24'h1F_FFFC};
        vt[4] = '{32'h0020_0000, 4'h0, 1'b0, 0,   32'h0,         24'h0};
        vt[5] = '{32'h0200_0008, 4'h0, 1'b0, 0,   32'h0,         24'h0};
        vt[6] = '{32'h000F_FFFC, 4'h0, 1'b0, 0,   32'h0,         24'h0};
        vt[7] = '{32'h0010_0010, 4'hF, 1'b1, 1,   32'h0,         24'h0};

        #2 resetn = 1'b0;
        @(negedge clk);
        chk("rst_csn", flash_csn, 1);
        chk("rst_sck", flash_clk, 0);
        chk("rst_mosi", flash_mosi, 0);
        chk("rst_ready", mem_ready, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            do_reset();
            f0 = n_fall;
            run_op(vt[i].addr, vt[i].wstrb, (vt[i].lat > 0) ? 400 : 40);
            chk($sformatf("v%0d_sel", i), op_sel, vt[i].hit);
            chk($sformatf("v%0d_lat", i), op_lat, (vt[i].lat > 0) ? vt[i].lat : -1);
            if (vt[i].lat > 0) begin
                chk($sformatf("v%0d_rdata", i), op_data, vt[i].data);
                chk($sformatf("v%0d_pulse", i), op_rdy_after, 0);
            end
            if (vt[i].hit && vt[i].wstrb == 4'h0) begin
                chk($sformatf("v%0d_csn_t1", i), op_csn1, 0);
                chk($sformatf("v%0d_cmd", i), cap_cmd, 8'h03);
                chk($sformatf("v%0d_faddr", i), cap_addr, vt[i].faddr);
                chk($sformatf("v%0d_nfall", i), n_fall - f0, 1);
            end else begin
                chk($sformatf("v%0d_nfall", i), n_fall - f0, 0);
            end
        end

        // Two reads at consecutive word addresses.
        do_reset();
        run_op(32'h0010_0000, 4'h0, 400);
        chk("seq1_rdata", op_data, 32'h4433_2211);
        bc = 0;
        while (busy && bc < 20) begin
            @(posedge clk);
            #1 bc++;
        end
        chk("seq_gap_busy", bc, GAP_BUSY);
        r0 = n_rise;
        h0 = nhdr;
        run_op(32'h0010_0004, 4'h0, 400);
        chk("seq2_lat", op_lat, SEQ_LAT);
        chk("seq2_rdata", op_data, 32'h8877_6655);
`ifdef SPIFLASH_SEQ_EN
        chk("seq2_csn_rises", n_rise - r0, 0);
        chk("seq2_no_header", nhdr - h0, 0);
`else
        chk("seq2_header", nhdr - h0, 1);
        chk("seq2_faddr", cap_addr, 24'h10_0004);
        chk("seq2_gap_ge4", last_gap >= 4, 1);
`endif

        // Write after a read leaves mem_rdata alone and never selects the flash.
        do_reset();
        run_op(32'h0010_0000, 4'h0, 400);
        repeat (10) @(posedge clk);
        f0 = n_fall;
        run_op(32'h0010_0010, 4'hF, 40);
        chk("wr_lat", op_lat, WR_LAT);
        chk("wr_rdata_kept", op_data, 32'h4433_2211);
        chk("wr_pulse", op_rdy_after, 0);
        chk("wr_nfall", n_fall - f0, 0);
        chk("wr_csn_high", flash_csn, 1);

        // Reset during the DATA phase, then a clean read.
        do_reset();
        run_op(32'h0010_0000, 4'h0, 400);
        repeat (10) @(posedge clk);
        @(posedge clk);
        #1;
        mem_addr  = 32'h0010_0008;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        rdy_seen  = 1'b0;
        repeat (200) begin
            @(posedge clk);
            #1 if (mem_ready) rdy_seen = 1'b1;
        end
        chk("mid_busy_before", busy, 1);
        chk("mid_csn_before", flash_csn, 0);
        resetn = 1'b0;
        #1;
        chk("mid_csn", flash_csn, 1);
        chk("mid_sck", flash_clk, 0);
        chk("mid_ready", mem_ready, 0);
        chk("mid_rdata", mem_rdata, 0);
        chk("mid_busy", busy, 0);
        repeat (3) begin
            @(posedge clk);
            #1 if (mem_ready) rdy_seen = 1'b1;
        end
        mem_valid = 1'b0;
        resetn    = 1'b1;
        chk("mid_no_ready", rdy_seen, 0);
        repeat (2) @(posedge clk);
        run_op(32'h0010_0008, 4'h0, 400);
        chk("post_lat", op_lat, 257);
        chk("post_rdata", op_data, 32'hCCBB_AA99);
        chk("post_faddr", cap_addr, 24'h10_0008);

        chk("sck_while_csn_high", sck_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spiflash_responder.md
# spiflash_responder

Memory-mapped SPI flash read port on the picorv32 native memory bus. Decodes a fixed address window (default the boot image at 1 MB into flash) and answers each word read with a SPI READ (0x03) sequence. It returns the word on `mem_rdata` with a one-cycle `mem_ready` pulse. The system-level ready/rdata mux selects this block via `sel`, alongside RAM and simpleuart.

## Interface
- `BASE_ADDR`, 32'h0010_0000: first bus byte address of the window.
- `WINDOW_BYTES`, 32'h0010_0000: window size. Hit when `BASE_ADDR <= mem_addr < BASE_ADDR+WINDOW_BYTES`.
- `HALF_PERIOD`, 2: `clk` cycles per SCK half-period. Must be ≥1.

Ports:
- `clk`, in, 1: system clock (core clock).
- `resetn`, in, 1: asynchronous, active-low reset.
- `mem_valid`, in, 1: core request strobe.
- `mem_addr`, in, 32: byte address.
- `mem_wstrb`, in, 4: nonzero means write.
- `sel`, out, 1: combinational, `mem_valid` && window hit.
- `mem_ready`, out, 1: one-cycle completion pulse.
- `mem_rdata`, out, 32: read word.
- `flash_csn`, out, 1: chip select, active low.
- `flash_clk`, out, 1: SCK, SPI mode 0.
- `flash_mosi`, out, 1: serial data to flash.
- `flash_miso`, in, 1: serial data from flash.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, ACK, CMD (8 bits), ADDR (24 bits), DATA (32 bits), DONE, HOLD (macro only), GAP.
- **IDLE, read:** `sel` && `mem_wstrb==0` → CMD. Latch flash address = `mem_addr[23:2],2'b00`. Unaligned addresses are word-aligned.
- **IDLE, write:** `sel` && `mem_wstrb!=0` → ACK. ACK pulses `mem_ready` → IDLE. No SPI activity; `mem_rdata` is unchanged.
- **Shift rules:**
  - MSB first.
  - MOSI updates while SCK is low.
  - MISO is sampled on the `clk` edge that ends each SCK-high phase.
  - MOSI is driven 0 during DATA.
- **Byte order:** little-endian. Byte at flash address A → `mem_rdata[7:0]`; A+3 → `[31:24]`.
- **DONE:** `mem_ready`=1 for one cycle if `mem_valid` is still high; otherwise the result is discarded silently. `mem_rdata` holds until the next read completes.
- **GAP:** `flash_csn` high, SCK 0, for 2*`HALF_PERIOD` cycles before any new command.
- **Reset values:**
  - `flash_csn`=1, `flash_clk`=0, `flash_mosi`=0.
  - `mem_ready`=0, `mem_rdata`=0, `busy`=0, state IDLE.
- **Reset mid-operation:** outputs return to reset values immediately (asynchronous). No `mem_ready` is issued.
- **Request changes:** `mem_addr`/`mem_wstrb` changes during a transaction are ignored.

## Timing
- T0 is the cycle `sel` is seen in IDLE.
- T0+1: `flash_csn` falls, and the first command bit is on MOSI.
- Each bit takes 2*`HALF_PERIOD` cycles: SCK low, then SCK high.
- Full read is 64 bits. `mem_ready` is asserted at T0+1+128*`HALF_PERIOD`, which is T0+257 at the default.
- Without the macro, `flash_csn` rises in the DONE cycle, and GAP follows.
- Write: `mem_ready` at T0+1.
- SCK idles low. No SCK edges occur while `flash_csn` is high.

## Configuration
- **`SPIFLASH_SEQ_EN` defined:**
  - After DONE → HOLD: `flash_csn` stays low, SCK stays 0.
  - In HOLD, a read hit whose word address equals last+4 → DATA directly, with no command or address phase. `mem_ready` at T0+1+64*`HALF_PERIOD` (T0+129 at the default).
  - Any other hit (non-sequential read or write) → `flash_csn` high, GAP, then the normal path. Writes ACK after GAP.
  - Last address wraps at 2^24.
- **Undefined:** HOLD is removed. Every read issues the full command/address sequence followed by GAP.

## Test plan
- **Reset:** assert `resetn`=0 → `flash_csn`=1, `flash_clk`=0, `mem_ready`=0, `mem_rdata`=0, `busy`=0.
- **Single read:** read 0x0010_0000, flash model bytes 11 22 33 44 → MOSI 03 10 00 00, `mem_rdata`=0x4433_2211, single `mem_ready` at T0+257.
- **Unaligned read / window decode:**
  - Read 0x0010_0006 → flash address 0x100004.
  - Read 0x0200_0008 → `sel`=0, no `flash_csn` activity.
  - Read 0x001F_FFFC → hit.
  - Read 0x0020_0000 → miss.
- **Write:** write 0xDEAD_BEEF to 0x0010_0010 → `mem_ready` at T0+1, `flash_csn` stays 1, `mem_rdata` unchanged.
- **Sequential reads:** read 0x100000, then 0x100004.
  - With `SPIFLASH_SEQ_EN`: second `mem_ready` at T0+129, `flash_csn` low throughout, no 0x03 resent.
  - Without the macro: T0+257, `flash_csn` high ≥4 cycles between reads.
- **Reset mid-read:** `resetn` low during the DATA phase → same-cycle `flash_csn`=1, SCK 0, no `mem_ready`. A read after release completes normally.
